ps2_frame_rx: RTL and testbench

//  Parametrised PS/2-style serial frame receiver; next generation of the keyboard bit receiver.

---
 rtl/ps2_rx_pkg.sv | 18 +
 rtl/ps2_line_filter.sv | 57 +++++
 rtl/ps2_frame_rx.sv | 129 ++++++++++++
 tb/tb_ps2_frame_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_pkg.sv
// Shared types and helpers for the PS/2 frame receiver.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX    = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int frame_bits(input int data_bits, input int parity_mode);
        return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + 1;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 pins and debounces kbd_clk; emits a pulse on each
// filtered falling edge (fall) and on any filtered edge (chg).
module ps2_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic kbd_clk,
    input  logic kbd_dat,
    output logic dat_s,
    output logic fall,
    output logic chg
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_f_q;
    logic [CW-1:0] cnt_q;
    logic          fall_q;
    logic          chg_q;
    logic          clk_s;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = fall_q;
    assign chg   = chg_q;

    // cnt_q counts consecutive synced samples that disagree with the filtered level.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_f_q    <= 1'b0;
            cnt_q      <= '0;
            fall_q     <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], kbd_clk};
            dat_sync_q <= {dat_sync_q[0], kbd_dat};
            fall_q     <= 1'b0;
            chg_q      <= 1'b0;
            if (clk_s == clk_f_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                clk_f_q <= clk_s;
                cnt_q   <= '0;
                chg_q   <= 1'b1;
                fall_q  <= clk_f_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2-style frame receiver: start/data/parity/stop deframing with error pulses.
// Define PS2_RX_TIMEOUT_EN to build the mid-frame watchdog abort.
module ps2_frame_rx
    import ps2_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 kbd_clk,
    input  logic                 kbd_dat,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_new,
    output logic                 parity_ok,
    output logic                 frame_err,
    output logic                 timeout_err
);

    localparam int FB   = frame_bits(DATA_BITS, PARITY_MODE);
    localparam int SR_W = FB - 1;
    localparam int CW   = $clog2(FB + 1);

    logic dat_s;
    logic fall;
    logic clk_chg;
    logic wd_hit;

    rx_state_e            state_q;
    logic [CW-1:0]        cntr_q;
    logic [SR_W-1:0]      sr_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 dout_new_q;
    logic                 parity_ok_q;
    logic                 frame_err_q;
    logic                 timeout_err_q;

    logic par_x;
    logic par_ok_w;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk     (clk),
        .resetN  (resetN),
        .kbd_clk (kbd_clk),
        .kbd_dat (kbd_dat),
        .dat_s   (dat_s),
        .fall    (fall),
        .chg     (clk_chg)
    );

    // After the stop bit is shifted in: sr_q = {stop, [parity], data}.
    assign par_x    = ^sr_q[DATA_BITS:0];
    assign par_ok_w = (PARITY_MODE == PARITY_NONE) ? 1'b1 :
                      (PARITY_MODE == PARITY_ODD)  ? par_x : ~par_x;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_q;

    assign wd_hit = (state_q == RX) && !clk_chg && (wd_q == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                        wd_q <= '0;
        else if (clk_chg || state_q != RX)  wd_q <= '0;
        else                                wd_q <= wd_q + 1'b1;
    end
`else
    localparam int unused_to = TIMEOUT_CYC;
    logic unused_chg;
    assign unused_chg = clk_chg;
    assign wd_hit     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            cntr_q        <= '0;
            sr_q          <= '0;
            dout_q        <= '0;
            dout_new_q    <= 1'b0;
            parity_ok_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            dout_new_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall && !dat_s) begin
                        state_q <= RX;
                        cntr_q  <= '0;
                        sr_q    <= '0;
                    end
                end
                RX: begin
                    if (wd_hit) begin
                        state_q       <= IDLE;
                        timeout_err_q <= 1'b1;
                    end else if (fall) begin
                        sr_q   <= {dat_s, sr_q[SR_W-1:1]};
                        cntr_q <= cntr_q + 1'b1;
                        if (cntr_q == CW'(FB - 2)) state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q     <= IDLE;
                    parity_ok_q <= par_ok_w;
                    if (!sr_q[SR_W-1]) begin
                        frame_err_q <= 1'b1;
                    end else if (par_ok_w) begin
                        dout_q     <= sr_q[DATA_BITS-1:0];
                        dout_new_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout        = dout_q;
    assign dout_new    = dout_new_q;
    assign parity_ok   = parity_ok_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: 8-bit odd-parity and 7-bit even-parity instances.
module tb_ps2_frame_rx;

    localparam int K_NEW  = 0;
    localparam int K_PBAD = 1;
    localparam int K_FERR = 2;
    localparam int K_TO   = 3;

    typedef struct {
        int         kind;
        logic [8:0] d;
        logic       pok;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic kc0 = 1'b1, kd0 = 1'b1, kc1 = 1'b1, kd1 = 1'b1;

    logic [7:0] d0;
    logic       dn0, pok0, fe0, to0;
    logic [6:0] d1;
    logic       dn1, pok1, fe1, to1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    logic pp   [2];
    logic ppok [2];

    always #5 clk = ~clk;

    ps2_frame_rx #(.DATA_BITS(8), .PARITY_MODE(1), .FILT_LEN(4), .TIMEOUT_CYC(100)) u0 (
        .clk(clk), .resetN(resetN), .kbd_clk(kc0), .kbd_dat(kd0),
        .dout(d0), .dout_new(dn0), .parity_ok(pok0), .frame_err(fe0), .timeout_err(to0)
    );

    ps2_frame_rx #(.DATA_BITS(7), .PARITY_MODE(2), .FILT_LEN(4), .TIMEOUT_CYC(100)) u1 (
        .clk(clk), .resetN(resetN), .kbd_clk(kc1), .kbd_dat(kd1),
        .dout(d1), .dout_new(dn1), .parity_ok(pok1), .frame_err(fe1), .timeout_err(to1)
    );

    task automatic mon(input int sel, input logic dn, input logic fe, input logic to,
                       input logic pok, input logic [8:0] d);
        exp_t e;
        logic any;
        any = dn | fe | to;
        if (pp[sel]) begin
            checks++;
            if (any) begin
                errors++;
                $display("FAIL pulse_width dut%0d: got dn=%b fe=%b to=%b on 2nd cycle, want all 0", sel, dn, fe, to);
            end
        end
        if (any || pok != ppok[sel]) begin
            checks++;
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_event dut%0d: got dn=%b fe=%b to=%b pok=%b dout=%h, want no event",
                         sel, dn, fe, to, pok, d);
            end else begin
                if (sel == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                if (dn !== (e.kind == K_NEW) || fe !== (e.kind == K_FERR) ||
                    to !== (e.kind == K_TO) || pok !== e.pok || d !== e.d) begin
                    errors++;
                    $display("FAIL event dut%0d: got dn=%b fe=%b to=%b pok=%b dout=%h, want kind=%0d pok=%b dout=%h",
                             sel, dn, fe, to, pok, d, e.kind, e.pok, e.d);
                end
            end
        end
        pp[sel]   = any;
        ppok[sel] = pok;
    endtask

    always @(negedge clk) begin
        if (!resetN) begin
            pp[0] = 1'b0; pp[1] = 1'b0; ppok[0] = 1'b0; ppok[1] = 1'b0;
        end else begin
            mon(0, dn0, fe0, to0, pok0, {1'b0, d0});
            mon(1, dn1, fe1, to1, pok1, {2'b0, d1});
        end
    end

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push(input int sel, input int kind, input logic [8:0] d, input logic pok);
        exp_t e;
        e.kind = kind; e.d = d; e.pok = pok;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive(input int sel, input logic c, input logic d);
        if (sel == 0) begin kc0 = c; kd0 = d; end
        else          begin kc1 = c; kd1 = d; end
    endtask

    // bits[0] is the start bit; a 2-cycle low glitch is inserted in the high phase of bit glitch_at.
    task automatic send(input int sel, input logic [10:0] bits, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b1, bits[i]);
            wait_cyc(10);
            if (i == glitch_at) begin
                drive(sel, 1'b0, bits[i]);
                wait_cyc(2);
                drive(sel, 1'b1, bits[i]);
                wait_cyc(6);
            end
            drive(sel, 1'b0, bits[i]);
            wait_cyc(20);
            drive(sel, 1'b1, bits[i]);
            wait_cyc(10);
        end
        drive(sel, 1'b1, 1'b1);
    endtask

    function automatic logic [10:0] f8(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    function automatic logic [10:0] f7(input logic [6:0] d, input logic p, input logic s);
        return {1'b1, s, p, d, 1'b0};
    endfunction

    task automatic wait_drain(input int bound);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < bound) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending events, want 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout0"}, {1'b0, d0}, 9'h0);
        chk({tag, "_pulses0"}, {6'b0, dn0, fe0, to0}, 9'h0);
        chk({tag, "_pok0"}, {8'b0, pok0}, 9'h0);
        chk({tag, "_dout1"}, {2'b0, d1}, 9'h0);
        chk({tag, "_pulses1"}, {6'b0, dn1, fe1, to1}, 9'h0);
        chk({tag, "_pok1"}, {8'b0, pok1}, 9'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        wait_cyc(3);
        @(negedge clk);
        chk_zero("reset");
        resetN = 1'b1;
        wait_cyc(20);

        push(0, K_NEW, 9'h1C, 1'b1);
        send(0, f8(8'h1C, 1'b0, 1'b1), 11, -1);
        wait_drain(50);

        push(0, K_PBAD, 9'h1C, 1'b0);
        send(0, f8(8'hF0, 1'b0, 1'b1), 11, -1);
        wait_drain(50);

        push(0, K_FERR, 9'h1C, 1'b1);
        send(0, f8(8'h55, 1'b1, 1'b0), 11, -1);
        wait_drain(50);

        push(0, K_NEW, 9'h1C, 1'b1);
        send(0, f8(8'h1C, 1'b0, 1'b1), 11, -1);
        wait_drain(50);

        // idle glitch with data low: would look like a start bit if it got through
        drive(0, 1'b1, 1'b0); wait_cyc(10);
        drive(0, 1'b0, 1'b0); wait_cyc(2);
        drive(0, 1'b1, 1'b0); wait_cyc(10);
        drive(0, 1'b1, 1'b1); wait_cyc(10);
        push(0, K_NEW, 9'h29, 1'b1);
        send(0, f8(8'h29, 1'b0, 1'b1), 11, 3);
        wait_drain(50);

        push(1, K_NEW, 9'h41, 1'b1);
        send(1, f7(7'h41, 1'b0, 1'b1), 10, -1);
        wait_drain(50);

        push(1, K_PBAD, 9'h41, 1'b0);
        send(1, f7(7'h03, 1'b1, 1'b1), 10, -1);
        wait_drain(50);

`ifdef PS2_RX_TIMEOUT_EN
        push(0, K_TO, 9'h29, 1'b1);
        send(0, f8(8'h00, 1'b0, 1'b1), 4, -1);
        n = 0;
        while (!to0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 93 || n > 103) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, want 93..103", n);
        end
        wait_drain(50);
        push(0, K_NEW, 9'hF0, 1'b1);
        send(0, f8(8'hF0, 1'b1, 1'b1), 11, -1);
        wait_drain(50);
`else
        // without the watchdog the partial frame just hangs in RX
        send(0, f8(8'h00, 1'b0, 1'b1), 4, -1);
        wait_cyc(300);
        n = 0;
`endif

        send(0, f8(8'hA5, 1'b1, 1'b1), 5, -1);
        send(1, f7(7'h15, 1'b1, 1'b1), 5, -1);
        resetN = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        chk_zero("midreset");
        resetN = 1'b1;
        wait_cyc(100);
        wait_drain(1);

        push(0, K_NEW, 9'h1C, 1'b1);
        send(0, f8(8'h1C, 1'b0, 1'b1), 11, -1);
        wait_drain(50);
        push(1, K_NEW, 9'h41, 1'b1);
        send(1, f7(7'h41, 1'b0, 1'b1), 10, -1);
        wait_drain(50);
        wait_cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
